muldiv_unit: RTL and testbench

Parametrised RV32M/RV64M multiply–divide unit in the execute stage, beside the ALU. It decodes `funct3` of an M-extension instruction into one of eight operations. Results are computed iteratively, with early-out for divide special cases. A start/busy/done handshake lets the hazard unit stall the pipeline while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_iter.sv | 60 ++++++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constant helpers for the M-extension multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  localparam int XLEN_MAX = 64;

  // Most negative signed value of an xlen-bit word (overflow dividend).
  function automatic logic [XLEN_MAX-1:0] signed_min(input int xlen);
    return {{(XLEN_MAX-1){1'b0}}, 1'b1} << (xlen - 1);
  endfunction

  // All-ones xlen-bit word: divide-by-zero quotient and the -1 divisor.
  function automatic logic [XLEN_MAX-1:0] all_ones(input int xlen);
    return {XLEN_MAX{1'b1}} >> (XLEN_MAX - xlen);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared radix-2 datapath: shift-add multiply or restoring divide on magnitudes.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
);

  // acc = {high half, low half}: multiply keeps partial sum / multiplier,
  // divide keeps partial remainder / dividend shifting into quotient.
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opb;
  logic              mode;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = rem_sh - {1'b0, opb};
    acc_next = {mul_sum, acc[XLEN-1:1]};
    if (mode) begin
      if (!diff[XLEN])
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      opb  <= '0;
      mode <= 1'b0;
    end else if (load) begin
      acc  <= {{XLEN{1'b0}}, a};
      opb  <= b;
      mode <= div_mode;
    end else if (step) begin
      acc <= acc_next;
    end
  end

  assign prod = acc;
  assign quot = acc[XLEN-1:0];
  assign rem  = acc[2*XLEN-1:XLEN];

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit with start/busy/done handshake for pipeline stalls.
//   state   | meaning
//   IDLE    | waiting for startE
//   CALC    | one multiply/divide iteration per cycle, counter down to 0
//   FIX     | apply signs, select and register result
//   DONE    | done pulse; may accept the next op back-to-back
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            startE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] srcaE,
  input  logic [XLEN-1:0] srcbE,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = XLEN'(signed_min(XLEN));
  localparam logic [XLEN-1:0] ONES = XLEN'(all_ones(XLEN));
  localparam bit              FAST = (FAST_MUL != 0);

  muldiv_state_e state, state_d;
  muldiv_op_e    op_in, op_q;
  logic [CW-1:0] cnt, cnt_d;
  logic          neg_q, neg_r;

  logic            sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, early;
  logic [2*XLEN-1:0] fast_prod, fast_prod_s;
  logic [XLEN-1:0] early_res, fix_res, res_d;
  logic            load, step, res_en, done_d;

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot, quot_s, rem, rem_s;

  assign op_in = muldiv_op_e'(funct3E);
  assign sgn_a = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sgn_b = op_in inside {OP_MULH, OP_DIV, OP_REM};
  assign a_neg = sgn_a & srcaE[XLEN-1];
  assign b_neg = sgn_b & srcbE[XLEN-1];
  assign a_mag = a_neg ? -srcaE : srcaE;
  assign b_mag = b_neg ? -srcbE : srcbE;

  assign div_zero = (srcbE == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (srcaE == SMIN) && (srcbE == ONES);
  assign early    = (~funct3E[2] & FAST) | (funct3E[2] & (div_zero | div_ovf));

  assign fast_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign fast_prod_s = (a_neg ^ b_neg) ? -fast_prod : fast_prod;

  always_comb begin
    early_res = '0;
    if (!funct3E[2])
      early_res = (op_in == OP_MUL) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
    else if (div_zero)
      early_res = funct3E[1] ? srcaE : ONES;
    else if (op_in == OP_DIV)
      early_res = SMIN;
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .div_mode (funct3E[2]),
    .a        (a_mag),
    .b        (b_mag),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem)
  );

  // Remainder sign follows the dividend; quotient/product sign is the xor.
  assign prod_s = neg_q ? -prod : prod;
  assign quot_s = neg_q ? -quot : quot;
  assign rem_s  = neg_r ? -rem  : rem;

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                        fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quot_s;
      default:                       fix_res = rem_s;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    step    = 1'b0;
    res_en  = 1'b0;
    res_d   = fix_res;
    done_d  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (startE) begin
          if (early) begin
            state_d = ST_DONE;
            res_en  = 1'b1;
            res_d   = early_res;
            done_d  = 1'b1;
          end else begin
            state_d = ST_CALC;
            load    = 1'b1;
            cnt_d   = CW'(XLEN - 1);
          end
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (cnt == '0) state_d = ST_FIX;
        else           cnt_d   = cnt - CW'(1);
      end
      ST_FIX: begin
        res_en  = 1'b1;
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      load    = 1'b0;
      step    = 1'b0;
      res_en  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      done  <= done_d;
      if (load) begin
        op_q  <= op_in;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
      if (res_en) result <= res_d;
    end
  end

  assign busy = (state == ST_CALC) || (state == ST_FIX);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; iterative and fast-multiply instances share stimulus.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        startE;
  logic [2:0]  funct3E;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flush;
  logic        busy, done, busy_f, done_f;
  logic [31:0] result, result_f;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32), .FAST_MUL(0)) dut (
    .clk(clk), .rst_n(rst_n), .startE(startE), .funct3E(funct3E),
    .srcaE(srcaE), .srcbE(srcbE), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  muldiv_unit #(.XLEN(32), .FAST_MUL(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .startE(startE), .funct3E(funct3E),
    .srcaE(srcaE), .srcbE(srcbE), .flush(flush),
    .busy(busy_f), .done(done_f), .result(result_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, wait for done (bounded), check latency, busy length and results.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input int lat_f);
    int n, nb, nf;
    @(negedge clk);
    startE = 1'b1; funct3E = f3; srcaE = a; srcbE = b;
    @(posedge clk); #1;
    startE = 1'b0;
    n = 1; nb = 0; nf = 0;
    while (n < 200) begin
      if (busy) nb++;
      if (done_f && nf == 0) nf = n;
      if (done) break;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " busy cycles"}, nb, lat - 1);
    check({tag, " result"}, result, exp);
    check({tag, " fast latency"}, nf, lat_f);
    check({tag, " fast result"}, result_f, exp);
  endtask

  initial begin
    int n, n1, d;
    rst_n = 1'b0; startE = 1'b0; funct3E = 3'b000;
    srcaE = '0; srcbE = '0; flush = 1'b0;
    #2;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset fast result", result_f, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mul",    3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1);
    run_op("mulh",   3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 34, 1);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1);
    run_op("div",    3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34, 34);
    run_op("rem",    3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34, 34);
    run_op("divu0",  3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1,  1);
    run_op("remu0",  3'b111, 32'd5,          32'd0,        32'd5,        1,  1);
    run_op("divovf", 3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1,  1);
    run_op("removf", 3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1,  1);
    run_op("divu",   3'b101, 32'd100,        32'd7,        32'd14,       34, 34);
    run_op("remu",   3'b111, 32'd100,        32'd7,        32'd2,        34, 34);

    // Flush mid-DIV, with an early-out request issued while busy.
    @(negedge clk);
    startE = 1'b1; funct3E = 3'b100; srcaE = 32'd100; srcbE = 32'd7;
    @(posedge clk); #1;
    startE = 1'b0;
    @(negedge clk);
    startE = 1'b1; funct3E = 3'b101; srcaE = 32'd5; srcbE = 32'd0;
    @(posedge clk); #1;
    startE = 1'b0;
    check("start while busy ignored busy", busy, 1);
    check("start while busy ignored done", done, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush busy low", busy, 0);
    @(negedge clk);
    flush = 1'b0;
    d = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) d++;
    end
    check("flush no done", d, 0);
    check("flush result kept", result, 32'd2);

    // startE and flush together in IDLE.
    @(negedge clk);
    startE = 1'b1; flush = 1'b1; funct3E = 3'b101; srcaE = 32'd5; srcbE = 32'd0;
    @(posedge clk); #1;
    check("start+flush busy", busy, 0);
    check("start+flush done", done, 0);
    @(negedge clk);
    startE = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    check("start+flush done later", done, 0);
    check("start+flush result", result, 32'd2);

    // Reset asserted mid-CALC.
    @(negedge clk);
    startE = 1'b1; funct3E = 3'b000; srcaE = 32'd7; srcbE = 32'hFFFFFFFD;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    check("mid reset result", result, 0);
    check("mid reset fast result", result_f, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back DIVU then MULHU, second start in the DONE cycle.
    @(negedge clk);
    startE = 1'b1; funct3E = 3'b101; srcaE = 32'd100; srcbE = 32'd7;
    @(posedge clk); #1;
    startE = 1'b0;
    n = 1;
    while (n < 200 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    n1 = n;
    check("b2b first done cycle", n1, 34);
    check("b2b first result", result, 32'd14);
    @(negedge clk);
    startE = 1'b1; funct3E = 3'b011; srcaE = 32'hFFFFFFFF; srcbE = 32'hFFFFFFFF;
    @(posedge clk); #1;
    startE = 1'b0;
    n++;
    while (n < 300 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b done spacing", n - n1, 34);
    check("b2b second result", result, 32'hFFFFFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
